// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the DVI receive path (also used by the encoder).
// Contents:
//   CTRL_TOKEN_00..11 : the four 10-bit control-period tokens, bit 0 first on the wire
//   align_state_e     : word-alignment FSM states
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } align_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder.
// Ports:
//   symbol  : 10-bit received symbol
//   data    : decoded video byte (meaningful when is_ctrl=0)
//   ctrl    : decoded control value {c1,c0} (meaningful when is_ctrl=1)
//   is_ctrl : symbol is one of the four control tokens
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] symbol,
  output logic [7:0] data,
  output logic [1:0] ctrl,
  output logic       is_ctrl
);

  logic [7:0] q;
  logic [6:0] diff;

  always_comb begin
    is_ctrl = 1'b1;
    ctrl    = 2'b00;
    case (symbol)
      CTRL_TOKEN_00: ctrl = 2'b00;
      CTRL_TOKEN_01: ctrl = 2'b01;
      CTRL_TOKEN_10: ctrl = 2'b10;
      CTRL_TOKEN_11: ctrl = 2'b11;
      default:       is_ctrl = 1'b0;
    endcase
  end

  // Bit 9 flags DC-balance inversion; bit 8 selects XOR (1) or XNOR (0) chaining.
  always_comb begin
    q    = symbol[9] ? ~symbol[7:0] : symbol[7:0];
    diff = q[7:1] ^ q[6:0];
    data = {(symbol[8] ? diff : ~diff), q[0]};
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS receive decoder for one channel with word-alignment (bitslip) control.
// Ports:
//   clk_in        : pixel clock
//   rst_n_in      : asynchronous active-low reset
//   tmds_in       : received 10-bit symbol, bit 0 first on the wire
//   data_out      : decoded video byte, valid when ve_out=1
//   control_out   : decoded control value, valid when ctl_valid_out=1
//   ve_out        : 1 = data symbol, 0 = control period
//   ctl_valid_out : symbol matched a control token
//   locked_out    : word alignment achieved
//   bitslip_out   : one-cycle request to shift the deserializer by one bit
// Decode latency is two cycles (input register, output register). The alignment FSM
// looks at the stage-1 symbol so locked_out moves in step with the decode outputs.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTL_RUN        = 12,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SLIP_WAIT      = 16,
  parameter int unsigned LOSS_TIMEOUT   = 8192
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       ctl_valid_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int unsigned RunW  = $clog2(CTL_RUN) + 1;
  localparam int unsigned ToW   = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int unsigned SlipW = $clog2(SLIP_WAIT) + 1;
  localparam int unsigned LossW = $clog2(LOSS_TIMEOUT) + 1;

  // Terminal values: an event fires when the counter already holds its last value,
  // so the increments below can never pass the limit (saturating by construction).
  localparam logic [RunW-1:0]  RunLast  = RunW'(CTL_RUN - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(SEARCH_TIMEOUT - 1);
  localparam logic [SlipW-1:0] SlipLast = SlipW'(SLIP_WAIT - 1);
  localparam logic [LossW-1:0] LossLast = LossW'(LOSS_TIMEOUT - 1);

  logic [9:0] sym_q;
  logic [7:0] s1_data;
  logic [1:0] s1_ctrl;
  logic       s1_is_ctrl;

  align_state_e     state_q;
  logic [RunW-1:0]  run_q;
  logic [ToW-1:0]   timeout_q;
  logic [SlipW-1:0] slip_q;
  logic [LossW-1:0] loss_q;

  tmds_symbol_decode u_decode (
    .symbol  (sym_q),
    .data    (s1_data),
    .ctrl    (s1_ctrl),
    .is_ctrl (s1_is_ctrl)
  );

  // Decode pipeline; the field not refreshed by a symbol keeps its last value.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sym_q         <= '0;
      data_out      <= '0;
      control_out   <= '0;
      ve_out        <= 1'b0;
      ctl_valid_out <= 1'b0;
    end else begin
      sym_q <= tmds_in;
      if (s1_is_ctrl) begin
        ve_out        <= 1'b0;
        ctl_valid_out <= 1'b1;
        control_out   <= s1_ctrl;
      end else begin
        ve_out        <= 1'b1;
        ctl_valid_out <= 1'b0;
        data_out      <= s1_data;
      end
    end
  end

  // Word-alignment FSM with registered locked_out / bitslip_out.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= SEARCH;
      run_q       <= '0;
      timeout_q   <= '0;
      slip_q      <= '0;
      loss_q      <= '0;
      locked_out  <= 1'b0;
      bitslip_out <= 1'b0;
    end else begin
      bitslip_out <= 1'b0;
      unique case (state_q)
        SEARCH: begin
          // Lock is tested first so it wins over a coincident timeout.
          if (s1_is_ctrl && (run_q == RunLast)) begin
            state_q    <= LOCKED;
            locked_out <= 1'b1;
            run_q      <= '0;
            timeout_q  <= '0;
            loss_q     <= '0;
          end else if (timeout_q == ToLast) begin
            state_q     <= SLIP;
            bitslip_out <= 1'b1;
            slip_q      <= '0;
          end else begin
            timeout_q <= timeout_q + 1'b1;
            run_q     <= s1_is_ctrl ? run_q + 1'b1 : '0;
          end
        end
        SLIP: begin
          // Symbols are ignored while the deserializer settles after the shift.
          if (slip_q == SlipLast) begin
            state_q   <= SEARCH;
            slip_q    <= '0;
            run_q     <= '0;
            timeout_q <= '0;
          end else begin
            slip_q <= slip_q + 1'b1;
          end
        end
        LOCKED: begin
          if (s1_is_ctrl) begin
            loss_q <= '0;
          end else if (loss_q == LossLast) begin
            state_q    <= SEARCH;
            locked_out <= 1'b0;
            loss_q     <= '0;
            run_q      <= '0;
            timeout_q  <= '0;
          end else begin
            loss_q <= loss_q + 1'b1;
          end
        end
        default: begin
          state_q    <= SEARCH;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder (SEARCH_TIMEOUT=64, LOSS_TIMEOUT=32).
module tb_tmds_decoder;
  import tmds_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out, ctl_valid_out, locked_out, bitslip_out;

  tmds_decoder #(
    .CTL_RUN        (12),
    .SEARCH_TIMEOUT (64),
    .SLIP_WAIT      (16),
    .LOSS_TIMEOUT   (32)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .tmds_in       (tmds_in),
    .data_out      (data_out),
    .control_out   (control_out),
    .ve_out        (ve_out),
    .ctl_valid_out (ctl_valid_out),
    .locked_out    (locked_out),
    .bitslip_out   (bitslip_out)
  );

  always #5 clk_in = ~clk_in;

  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  // TOK00 rotated by one bit: what a misaligned deserializer delivers.
  localparam logic [9:0] ROT   = 10'b1010101001;

  int total = 0;
  int bad   = 0;

  // Scoreboard entries: {data, control, ve, ctl_valid}.
  logic [11:0] sb[$];
  logic [7:0]  m_data;
  logic [1:0]  m_ctrl;
  logic        m_ve, m_cv;
  int          enc_cnt;

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] q;
    logic [7:0] d;
    q = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic model_apply(input logic [9:0] s);
    if (s == TOK00 || s == TOK01 || s == TOK10 || s == TOK11) begin
      m_ve = 1'b0;
      m_cv = 1'b1;
      m_ctrl = (s == TOK00) ? 2'b00 : (s == TOK01) ? 2'b01 : (s == TOK10) ? 2'b10 : 2'b11;
    end else begin
      m_ve = 1'b1;
      m_cv = 1'b0;
      m_data = ref_decode(s);
    end
  endtask

  // Reference DVI encoder with running-disparity tally.
  task automatic encode(input logic [7:0] d, output logic [9:0] s);
    logic [8:0] qm;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) enc_cnt = enc_cnt + n1q - n0q;
      else enc_cnt = enc_cnt + n0q - n1q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
    end
  endtask

  // Drive one symbol, record its expected result, advance one cycle (sample point #1 after).
  task automatic drive_sym(input logic [9:0] s);
    tmds_in = s;
    model_apply(s);
    sb.push_back({m_data, m_ctrl, m_ve, m_cv});
    @(posedge clk_in);
    #1;
  endtask

  // Assert reset, hold two edges, release; the reset stage-1 symbol (0) is modelled.
  task automatic apply_reset();
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    tmds_in = '0;
    sb.delete();
    m_data = '0;
    m_ctrl = '0;
    m_ve = 1'b0;
    m_cv = 1'b0;
    model_apply(10'h000);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    tmds_in = TOK11;
    #1;
    total++;
    if ({data_out, control_out, ve_out, ctl_valid_out, locked_out, bitslip_out} !== 14'h0) begin
      bad++;
      $display("FAIL reset_values got=%h want=0",
               {data_out, control_out, ve_out, ctl_valid_out, locked_out, bitslip_out});
    end
    apply_reset();
    total++;
    if (dut.state_q !== SEARCH) begin
      bad++;
      $display("FAIL reset_state got=%0d want=%0d", dut.state_q, SEARCH);
    end
    drive_sym(TOK11);
    drive_sym(10'h200);
    drive_sym(10'h200);
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if ({data_out, control_out, ve_out, ctl_valid_out, locked_out, bitslip_out} !== 14'h0) begin
      bad++;
      $display("FAIL reset_async got=%h want=0",
               {data_out, control_out, ve_out, ctl_valid_out, locked_out, bitslip_out});
    end
    apply_reset();
  endtask

  task automatic test_data_decode();
    logic [11:0] e;
    logic [9:0] pat[3] = '{10'h100, 10'h200, 10'h200};
    for (int n = 0; n < 3; n++) begin
      drive_sym(pat[n]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL data_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      if (n >= 1) begin
        total++;
        if ({data_out, ve_out} !== {((n == 1) ? 8'h00 : 8'hFF), 1'b1}) begin
          bad++;
          $display("FAIL data_const n=%0d got=%h ve=%b want=%h ve=1", n, data_out, ve_out,
                   (n == 1) ? 8'h00 : 8'hFF);
        end
      end
    end
  endtask

  task automatic test_control();
    logic [11:0] e;
    logic [9:0] pat[6] = '{TOK11, 10'h100, TOK00, TOK01, TOK10, 10'h200};
    for (int n = 0; n < 6; n++) begin
      drive_sym(pat[n]);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL ctrl_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      if (n == 1) begin
        // TOK11 visible now; data_out still holds the 8'hFF from the previous data symbol.
        total++;
        if ({ve_out, ctl_valid_out, control_out, data_out} !== {1'b0, 1'b1, 2'b11, 8'hFF}) begin
          bad++;
          $display("FAIL ctrl_tok11 got=%h want=%h",
                   {ve_out, ctl_valid_out, control_out, data_out}, {1'b0, 1'b1, 2'b11, 8'hFF});
        end
      end
    end
  endtask

  task automatic test_encoder_loop();
    logic [11:0] e;
    logic [9:0] s;
    enc_cnt = 0;
    for (int n = 0; n <= 256; n++) begin
      encode(8'(n), s);
      drive_sym(s);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL enc_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      if (n >= 1) begin
        total++;
        if ({data_out, ve_out} !== {8'(n - 1), 1'b1}) begin
          bad++;
          $display("FAIL enc_byte n=%0d got=%h ve=%b want=%h", n, data_out, ve_out, 8'(n - 1));
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [11:0] e;
    apply_reset();
    for (int n = 1; n <= 13; n++) begin
      drive_sym(TOK00);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL lock_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      total++;
      if (locked_out !== (n >= 13)) begin
        bad++;
        $display("FAIL lock_rise n=%0d got=%b want=%b", n, locked_out, n >= 13);
      end
    end
  endtask

  task automatic test_lock_restart();
    logic [11:0] e;
    apply_reset();
    for (int n = 0; n <= 24; n++) begin
      drive_sym((n == 11) ? 10'h100 : TOK00);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL restart_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      total++;
      if (locked_out !== (n >= 24)) begin
        bad++;
        $display("FAIL restart_lock n=%0d got=%b want=%b", n, locked_out, n >= 24);
      end
    end
  endtask

  task automatic test_bitslip();
    logic [11:0] e;
    apply_reset();
    // Pulses on cycles 64 and 144 (64 search + 16 settle); aligned tokens from 161.
    for (int n = 1; n <= 180; n++) begin
      drive_sym((n <= 160) ? ROT : TOK00);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL slip_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      total++;
      if (bitslip_out !== (n == 64 || n == 144)) begin
        bad++;
        $display("FAIL slip_pulse n=%0d got=%b want=%b", n, bitslip_out, n == 64 || n == 144);
      end
      total++;
      if (locked_out !== (n >= 173)) begin
        bad++;
        $display("FAIL slip_lock n=%0d got=%b want=%b", n, locked_out, n >= 173);
      end
    end
  endtask

  task automatic test_loss();
    logic [11:0] e;
    apply_reset();
    // Lock at 13; 31 data then a token keeps lock; 32 data drops it at 78.
    for (int n = 1; n <= 78; n++) begin
      drive_sym((n <= 13 || n == 45 || n == 78) ? TOK01 : 10'h100);
      if (sb.size() > 1) begin
        e = sb.pop_front();
        total++;
        if ({data_out, control_out, ve_out, ctl_valid_out} !== e) begin
          bad++;
          $display("FAIL loss_sb n=%0d got=%h want=%h", n,
                   {data_out, control_out, ve_out, ctl_valid_out}, e);
        end
      end
      total++;
      if ({locked_out, bitslip_out} !== {(n >= 13 && n < 78), 1'b0}) begin
        bad++;
        $display("FAIL loss_lock n=%0d got=%b%b want=%b0", n, locked_out, bitslip_out,
                 n >= 13 && n < 78);
      end
    end
    total++;
    if (dut.state_q !== SEARCH) begin
      bad++;
      $display("FAIL loss_state got=%0d want=%0d", dut.state_q, SEARCH);
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int n = 1; n <= 64; n++) drive_sym(ROT);
    total++;
    if (bitslip_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_slip_pulse got=%b want=1", bitslip_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if ({data_out, control_out, ve_out, ctl_valid_out, locked_out, bitslip_out} !== 14'h0) begin
      bad++;
      $display("FAIL mid_slip_reset got=%h want=0",
               {data_out, control_out, ve_out, ctl_valid_out, locked_out, bitslip_out});
    end
    apply_reset();
    for (int n = 1; n <= 13; n++) drive_sym(TOK10);
    total++;
    if (locked_out !== 1'b1) begin
      bad++;
      $display("FAIL mid_lock_pre got=%b want=1", locked_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    total++;
    if ({locked_out, bitslip_out} !== 2'b00) begin
      bad++;
      $display("FAIL mid_lock_reset got=%b%b want=00", locked_out, bitslip_out);
    end
    apply_reset();
    total++;
    if ({dut.state_q, locked_out} !== {SEARCH, 1'b0}) begin
      bad++;
      $display("FAIL mid_lock_state got=%0d/%b want=%0d/0", dut.state_q, locked_out, SEARCH);
    end
  endtask

  initial begin
    test_reset();
    test_data_decode();
    test_control();
    test_encoder_loop();
    test_lock();
    test_lock_restart();
    test_bitslip();
    test_loss();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
